// File: rtl/vga_timing_generator_if.sv
// Video-side bundle of the VGA timing generator: colour request in,
// raster coordinates, strobes, syncs and blanked video out.
interface vga_timing_generator_if #(
  parameter int COORD_W = 11
);
  logic [11:0]        i_color;
  logic [COORD_W-1:0] o_x;
  logic [COORD_W-1:0] o_y;
  logic               o_active;
  logic               o_pixel_tick;
  logic               o_line_start;
  logic               o_frame_start;
  logic               o_hsync;
  logic               o_vsync;
  logic [3:0]         o_red;
  logic [3:0]         o_green;
  logic [3:0]         o_blue;

  // Generator side
  modport master (
    input  i_color,
    output o_x, o_y, o_active, o_pixel_tick, o_line_start, o_frame_start,
    output o_hsync, o_vsync, o_red, o_green, o_blue
  );

  // Pixel source / DAC side
  modport slave (
    output i_color,
    input  o_x, o_y, o_active, o_pixel_tick, o_line_start, o_frame_start,
    input  o_hsync, o_vsync, o_red, o_green, o_blue
  );
endinterface

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing generator: pixel divider, x/y raster
// counters, line/frame strobes and a one-cycle registered sync/video stage.
module vga_timing_generator #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter bit HSYNC_POL = 1'b0,
  parameter bit VSYNC_POL = 1'b0,
  parameter int CLK_DIV   = 1,
  parameter int COORD_W   = 11
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  vga_timing_generator_if.master vif
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [COORD_W-1:0] H_LAST   = COORD_W'(H_TOTAL - 1);
  localparam logic [COORD_W-1:0] V_LAST   = COORD_W'(V_TOTAL - 1);
  localparam logic [COORD_W-1:0] H_ACT    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] HS_BEG   = COORD_W'(H_ACTIVE + H_FRONT);
  localparam logic [COORD_W-1:0] HS_END   = COORD_W'(H_ACTIVE + H_FRONT + H_SYNC);
  localparam logic [COORD_W-1:0] VS_BEG   = COORD_W'(V_ACTIVE + V_FRONT);
  localparam logic [COORD_W-1:0] VS_END   = COORD_W'(V_ACTIVE + V_FRONT + V_SYNC);

  logic [DIV_W-1:0]   div_cnt;
  logic [COORD_W-1:0] x_q;
  logic [COORD_W-1:0] y_q;
  logic               first_q;   // this cycle is the first one of a new line
  logic               tick_raw;
  logic               active;
  logic               in_hs;
  logic               in_vs;
  logic               hsync_q;
  logic               vsync_q;
  logic [11:0]        rgb_q;

  assign tick_raw = (div_cnt == DIV_LAST);
  assign active   = (x_q < H_ACT) && (y_q < V_ACT);
  assign in_hs    = (x_q >= HS_BEG) && (x_q < HS_END);
  assign in_vs    = (y_q >= VS_BEG) && (y_q < VS_END);

  // Pixel divider and raster counters; first_q marks the cycle after a wrap
  // (or after reset) so the line strobe fires once, not once per sub-cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      div_cnt <= '0;
      x_q     <= '0;
      y_q     <= '0;
      first_q <= 1'b1;
    end else begin
      first_q <= 1'b0;
      if (tick_raw) begin
        div_cnt <= '0;
        if (x_q == H_LAST) begin
          x_q     <= '0;
          first_q <= 1'b1;
          y_q     <= (y_q == V_LAST) ? '0 : y_q + COORD_W'(1);
        end else begin
          x_q <= x_q + COORD_W'(1);
        end
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end
    end
  end

  // Registered sync and blanked video, one i_clk behind the counters.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      hsync_q <= ~HSYNC_POL;
      vsync_q <= ~VSYNC_POL;
      rgb_q   <= '0;
    end else begin
      hsync_q <= in_hs ? HSYNC_POL : ~HSYNC_POL;
      vsync_q <= in_vs ? VSYNC_POL : ~VSYNC_POL;
      rgb_q   <= active ? vif.i_color : 12'h000;
    end
  end

  // Strobes are masked while reset is held.
  assign vif.o_x           = x_q;
  assign vif.o_y           = y_q;
  assign vif.o_active      = active;
  assign vif.o_pixel_tick  = tick_raw && !i_reset;
  assign vif.o_line_start  = first_q && !i_reset;
  assign vif.o_frame_start = first_q && !i_reset && (y_q == '0);
  assign vif.o_hsync       = hsync_q;
  assign vif.o_vsync       = vsync_q;
  assign vif.o_red         = rgb_q[11:8];
  assign vif.o_green       = rgb_q[7:4];
  assign vif.o_blue        = rgb_q[3:0];

endmodule

// File: doc/vga_timing_generator.md
Name: vga_timing_generator

Overview:
Parametrised VGA raster timing generator. Successor to the fixed 640x480 signal generator.
- Horizontal and vertical timings, sync polarities and pixel-clock divide ratio are parameters.
- Exposes explicit pixel coordinates and line/frame strobes instead of pseudo-clocks.
- Sits between the frame-buffer/pattern logic, which supplies colour per coordinate, and the VGA DAC pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FRONT, 16, horizontal front porch, pixels
H_SYNC, 96, horizontal sync width, pixels
H_BACK, 48, horizontal back porch, pixels
V_ACTIVE, 480, visible lines per frame
V_FRONT, 10, vertical front porch, lines
V_SYNC, 2, vertical sync width, lines
V_BACK, 33, vertical back porch, lines
HSYNC_POL, 0, asserted level of o_hsync (0 = active low)
VSYNC_POL, 0, asserted level of o_vsync (0 = active low)
CLK_DIV, 1, i_clk cycles per pixel (>=1)
COORD_W, 11, width of coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
i_clk  in  1  system clock
i_reset  in  1  synchronous reset, active high
i_color  in  12  {R,G,B} 4:4:4 colour for current (o_x, o_y)
o_x  out  COORD_W  current horizontal count, 0..H_TOTAL-1
o_y  out  COORD_W  current vertical count, 0..V_TOTAL-1
o_active  out  1  (o_x, o_y) inside visible area
o_pixel_tick  out  1  one-cycle pulse: counters advance at end of this cycle
o_line_start  out  1  one-cycle pulse, first cycle with o_x==0
o_frame_start  out  1  one-cycle pulse, first cycle with o_x==0 and o_y==0
o_hsync  out  1  horizontal sync, registered
o_vsync  out  1  vertical sync, registered
o_red, o_green, o_blue  out  4 each  registered video, zero when blanked

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise.
- Region order per line: active, front porch, sync, back porch. Vertical regions use the same order.
- Divider: div_cnt counts 0..CLK_DIV-1. o_pixel_tick=1 when div_cnt==CLK_DIV-1. With CLK_DIV=1, o_pixel_tick is constantly 1 outside reset.
- On tick: o_x increments. At H_TOTAL-1, o_x wraps to 0 and o_y increments. At V_TOTAL-1, o_y wraps to 0. o_x and o_y are stable for CLK_DIV cycles.
- o_active = (o_x < H_ACTIVE) && (o_y < V_ACTIVE), combinational from counters.
- o_line_start and o_frame_start: high for exactly one i_clk cycle, the first cycle after the wrap. They do not repeat across the CLK_DIV cycles.
- Video pipeline, one i_clk latency. Each cycle:
  - o_hsync <= HSYNC_POL when H_ACTIVE+H_FRONT <= o_x < H_ACTIVE+H_FRONT+H_SYNC, else ~HSYNC_POL.
  - o_vsync <= VSYNC_POL under the equivalent vertical condition, else ~VSYNC_POL.
  - {o_red,o_green,o_blue} <= o_active ? i_color : 0.
- Vsync is a function of o_y only and changes on line boundaries, aligned with the line's o_x==0.
- Reset, any time including mid-frame: next cycle div_cnt=0, o_x=0, o_y=0, o_pixel_tick=0, colour=0, o_hsync=~HSYNC_POL, o_vsync=~VSYNC_POL.
- First cycle after reset release: o_line_start=1 and o_frame_start=1.
- Reset is held for at least one cycle. While held, counters do not advance and all strobes are 0.
- No other state. Consumers keying off o_frame_start need no further qualification.

Test Plan:
1. Small params H 8/2/3/2 (total 15), V 4/1/2/1 (total 8), CLK_DIV=1, polarities 0; reset 3 cycles, release -> o_frame_start=1 on cycle 0 only, o_line_start every 15 cycles, o_frame_start every 120 cycles.
2. Same params, i_color=12'hABC constant -> video 12'hABC exactly when o_x<8 and o_y<4, one cycle delayed; zero elsewhere. 32 active pixels per frame.
3. Same params -> o_hsync low for 3 cycles starting one cycle after o_x==10. o_vsync low for exactly 30 cycles (lines 5-6), falling one cycle after o_x==0 of line 5.
4. CLK_DIV=3 -> o_x holds each value 3 cycles, o_pixel_tick period 3, line period 45 cycles, o_line_start pulse width 1 cycle.
5. HSYNC_POL=1, VSYNC_POL=1 -> sync levels inverted relative to scenario 3; idle level 0 after reset.
6. Assert reset at o_x=5, o_y=2 for 1 cycle -> next cycle o_x=0, o_y=0, colour 0, syncs idle. Following cycle o_frame_start=1 and counting restarts cleanly.
